pipe_reg_chain: RTL and testbench

PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

---
 rtl/pipe_reg_chain_pkg.sv | 8 +
 rtl/pipe_stage.sv | 38 +++
 rtl/pipe_reg_chain.sv | 97 +++++++++
 tb/tb_pipe_reg_chain.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_reg_chain_pkg.sv
// Shared pipeline encodings: instruction bubbles inserted on reset, flush and empty stages.
package pipe_reg_chain_pkg;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [15:0] NOP_INSTR_C = 16'h0001;
    localparam logic [31:0] NOP_BUBBLE  = NOP_INSTR;

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline slot: valid bit plus payload, with clear/load/hold control.
module pipe_stage
    import pipe_reg_chain_pkg::*;
#(
    parameter int unsigned   DW      = 32,
    parameter logic [DW-1:0] RST_VAL = DW'(NOP_INSTR)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_load,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    output logic [DW-1:0] o_data
);

    logic          r_valid;
    logic [DW-1:0] r_data;

    // A slot that loads nothing valid is parked on the bubble value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= RST_VAL;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= RST_VAL;
        end else if (i_load) begin
            r_valid <= i_valid;
            r_data  <= i_valid ? i_data : RST_VAL;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic register chain of DEPTH stages with bubble collapse, global hold and flush.
// Backpressure ripples combinationally from out_ready_i to in_ready_o (no skid buffer).
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int unsigned   DW      = 32,
    parameter int unsigned   DEPTH   = 2,
    parameter logic [DW-1:0] RST_VAL = DW'(NOP_INSTR)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       hold_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DW-1:0]              in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DW-1:0]              out_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_move;
    logic [DEPTH-1:0] w_accept;
    logic [DEPTH-1:0] w_src_valid;
    logic [DW-1:0]    w_data     [DEPTH];
    logic [DW-1:0]    w_src_data [DEPTH];
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [CW-1:0]    r_count;

    // A stage moves when its successor is free or itself moving; resolved from the output side back.
    always_comb begin
        w_move = '0;
        w_move[DEPTH-1] = !hold_i && out_ready_i;
        for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
            w_move[k] = !hold_i && (!w_valid[k+1] || w_move[k+1]);
        end
    end

    always_comb begin
        for (int k = 0; k < int'(DEPTH); k++) begin
            w_accept[k] = !hold_i && (!w_valid[k] || w_move[k]);
        end
    end

    assign in_ready_o  = rst && w_accept[0] && !flush_i;
    assign w_in_xfer   = in_valid_i && in_ready_o;
    assign out_valid_o = w_valid[DEPTH-1] && !hold_i;
    assign out_data_o  = w_data[DEPTH-1];
    assign w_out_xfer  = out_valid_o && out_ready_i;

    genvar k;
    generate
        for (k = 0; k < int'(DEPTH); k++) begin : g_stage
            if (k == 0) begin : g_head
                assign w_src_valid[k] = in_valid_i;
                assign w_src_data[k]  = in_data_i;
            end else begin : g_body
                assign w_src_valid[k] = w_valid[k-1];
                assign w_src_data[k]  = w_data[k-1];
            end

            pipe_stage #(
                .DW      (DW),
                .RST_VAL (RST_VAL)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .i_clear (flush_i),
                .i_load  (w_accept[k]),
                .i_valid (w_src_valid[k]),
                .i_data  (w_src_data[k]),
                .o_valid (w_valid[k]),
                .o_data  (w_data[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (flush_i) begin
            r_count <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_count <= r_count + CW'(1);
        end else if (!w_in_xfer && w_out_xfer) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign count_o = r_count;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain at DEPTH=3, DW=32: directed scenarios plus random traffic.
module tb_pipe_reg_chain;

    localparam int DW    = 32;
    localparam int DEPTH = 3;
    localparam int CW    = $clog2(DEPTH+1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk         = 1'b0;
    logic          rst         = 1'b0;
    logic          flush_i     = 1'b0;
    logic          hold_i      = 1'b0;
    logic          in_valid_i  = 1'b0;
    logic          out_ready_i = 1'b0;
    logic [DW-1:0] in_data_i   = '0;
    logic          in_ready_o;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic [CW-1:0] count_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] sb_q[$];

    pipe_reg_chain #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .hold_i      (hold_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: inputs are stable at the falling edge, so this sees what the next rising edge will see.
    always @(negedge clk) begin
        if (!rst) begin
            sb_q.delete();
        end else begin
            check("sb_count", 32'(count_o), 32'(sb_q.size()));
            if (out_valid_o && out_ready_i) begin
                if (sb_q.size() == 0) check("sb_spurious_out", 32'(out_valid_o), 32'd0);
                else                  check("sb_data", out_data_o, sb_q.pop_front());
            end
            if (flush_i)                       sb_q.delete();
            else if (in_valid_i && in_ready_o) sb_q.push_back(in_data_i);
        end
    end

    task automatic drive(input logic v, input logic [31:0] d);
        @(posedge clk);
        #1;
        in_valid_i = v;
        in_data_i  = d;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (n < 20 && (count_o != '0 || out_valid_o)) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(count_o), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_sb"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] vals [3];
        vals[0] = 32'hA1; vals[1] = 32'hA2; vals[2] = 32'hA3;

        // Reset behaviour and idle state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ov",   32'(out_valid_o), 32'd0);
        check("rst_ir",   32'(in_ready_o),  32'd0);
        check("rst_data", out_data_o,       NOP);
        check("rst_cnt",  32'(count_o),     32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("idle_ov",   32'(out_valid_o), 32'd0);
        check("idle_ir",   32'(in_ready_o),  32'd1);
        check("idle_data", out_data_o,       NOP);
        check("idle_cnt",  32'(count_o),     32'd0);

        // Latency and back-to-back throughput
        out_ready_i = 1'b1;
        for (int c = 0; c < 7; c++) begin
            drive(c < 3, (c < 3) ? vals[c] : 32'h0);
            @(negedge clk);
            check("lat_ov", 32'(out_valid_o), 32'(c >= 3 && c < 6));
            if (c >= 3 && c < 6) check("lat_data", out_data_o, vals[c-3]);
        end

        // Backpressure: three accepted, fourth refused
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(32'hB0 + i));
            @(negedge clk);
            check("bp_ready", 32'(in_ready_o), 32'(i < 3));
        end
        drive(1'b0, 32'h0);
        @(negedge clk);
        check("bp_cnt",  32'(count_o),     32'd3);
        check("bp_ov",   32'(out_valid_o), 32'd1);
        check("bp_head", out_data_o,       32'hB0);
        out_ready_i = 1'b1;
        wait_drain("bp_drain");

        // Hold with two entries resident
        out_ready_i = 1'b0;
        drive(1'b1, 32'hC0);
        drive(1'b1, 32'hC1);
        drive(1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            hold_i     = 1'b1;
            in_valid_i = 1'b1;
            in_data_i  = 32'hEE;
            out_ready_i = 1'b1;
            @(negedge clk);
            check("hold_ov",  32'(out_valid_o), 32'd0);
            check("hold_ir",  32'(in_ready_o),  32'd0);
            check("hold_cnt", 32'(count_o),     32'd2);
        end
        @(posedge clk);
        #1;
        hold_i     = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk);
        check("hold_rel_ov",   32'(out_valid_o), 32'd1);
        check("hold_rel_data", out_data_o,       32'hC0);
        wait_drain("hold_drain");

        // Flush wins over hold and drops the same-cycle input
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1, 32'(32'hD0 + i));
        @(posedge clk);
        #1;
        flush_i    = 1'b1;
        hold_i     = 1'b1;
        in_valid_i = 1'b1;
        in_data_i  = 32'h77;
        @(negedge clk);
        check("fl_ir", 32'(in_ready_o), 32'd0);
        @(posedge clk);
        #1;
        flush_i    = 1'b0;
        hold_i     = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk);
        check("fl_cnt",  32'(count_o),     32'd0);
        check("fl_ov",   32'(out_valid_o), 32'd0);
        check("fl_data", out_data_o,       NOP);
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("fl_empty_ov",   32'(out_valid_o), 32'd0);
            check("fl_empty_data", out_data_o,       NOP);
        end

        // Asynchronous reset mid-stream
        out_ready_i = 1'b0;
        drive(1'b1, 32'hE0);
        drive(1'b1, 32'hE1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_ov",   32'(out_valid_o), 32'd0);
        check("arst_ir",   32'(in_ready_o),  32'd0);
        check("arst_data", out_data_o,       NOP);
        check("arst_cnt",  32'(count_o),     32'd0);
        in_valid_i = 1'b0;
        @(posedge clk);
        #2;
        rst        = 1'b1;
        in_valid_i = 1'b1;
        in_data_i  = 32'hF1;
        @(negedge clk);
        check("arst_first_ir", 32'(in_ready_o), 32'd1);
        drive(1'b0, 32'h0);
        @(negedge clk);
        check("arst_first_cnt", 32'(count_o), 32'd1);
        out_ready_i = 1'b1;
        wait_drain("arst_drain");

        // Random traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            in_valid_i  = 1'($urandom_range(0, 1));
            in_data_i   = $urandom;
            out_ready_i = ($urandom_range(0, 3) != 0);
            hold_i      = ($urandom_range(0, 7) == 0);
            flush_i     = ($urandom_range(0, 31) == 0);
        end
        @(posedge clk);
        #1;
        in_valid_i  = 1'b0;
        hold_i      = 1'b0;
        flush_i     = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk);
        wait_drain("rnd_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
